ac_motor_vector_pwm: RTL and testbench

- Consumer of the SVPWM dwell times (t0, t1, t2, t7) and the sector number.
- Converts them into a centre-aligned, seven-segment switching sequence for the three inverter legs (U, V, W), with complementary high-side/low-side gates and dead time.
- Sits between the vector-time calculator and the gate-driver pins; one PWM period per latched set of times.

---
 rtl/ac_motor_vector_pwm.sv | 224 ++++++++++++++++++++++
 tb/tb_ac_motor_vector_pwm.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ac_motor_vector_pwm.sv
// ac_motor_vector_pwm: centre-aligned seven-segment SVPWM sequencer.
// Drives three complementary inverter legs with per-leg dead time.
module ac_motor_vector_pwm #(
    parameter int CLK_FREQ  = 100000000,
    parameter int PWM_FREQ  = 5000,
    parameter int T_WIDTH   = 15,
    parameter int DEAD_TIME = 50
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic [2:0]         sector,
    input  logic [T_WIDTH-1:0] t0,
    input  logic [T_WIDTH-1:0] t1,
    input  logic [T_WIDTH-1:0] t2,
    input  logic [T_WIDTH-1:0] t7,
    output logic               u_h,
    output logic               u_l,
    output logic               v_h,
    output logic               v_l,
    output logic               w_h,
    output logic               w_l,
    output logic               period_start,
    output logic               sum_error,
    output logic               sector_error
);

    localparam int PERIOD = CLK_FREQ / PWM_FREQ;
    localparam int CW     = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int BW0    = T_WIDTH + 2;
    localparam int BW     = (CW > BW0) ? CW : BW0;
    localparam int DW     = (DEAD_TIME > 0) ? $clog2(DEAD_TIME + 1) : 1;

    localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

    localparam logic [2:0] V0 = 3'b000;
    localparam logic [2:0] V1 = 3'b100;
    localparam logic [2:0] V2 = 3'b110;
    localparam logic [2:0] V3 = 3'b010;
    localparam logic [2:0] V4 = 3'b011;
    localparam logic [2:0] V5 = 3'b001;
    localparam logic [2:0] V6 = 3'b101;
    localparam logic [2:0] V7 = 3'b111;

    logic [CW-1:0]      cnt;
    logic               at_zero;
    logic [2:0]         lat_sector;
    logic [T_WIDTH-1:0] lat_t0;
    logic [T_WIDTH-1:0] lat_t1;
    logic [T_WIDTH-1:0] lat_t2;
    logic [T_WIDTH-1:0] lat_t7;
    logic               run;
    logic               drive;

    logic [2:0]         s_sec;
    logic [T_WIDTH-1:0] s_t0;
    logic [T_WIDTH-1:0] s_t1;
    logic [T_WIDTH-1:0] s_t2;
    logic [T_WIDTH-1:0] s_t7;
    logic [BW-1:0]      sum_in;
    logic [BW-1:0]      h0;
    logic [BW-1:0]      h1;
    logic [BW-1:0]      h2;
    logic [BW-1:0]      b1;
    logic [BW-1:0]      b2;
    logic [BW-1:0]      b3;
    logic [BW-1:0]      b4;
    logic [BW-1:0]      b5;
    logic [BW-1:0]      b6;
    logic [BW-1:0]      c;
    logic [2:0]         va;
    logic [2:0]         vb;
    logic               sec_ok;
    logic [2:0]         cmd;

    logic [2:0]         tgt;
    logic [2:0]         gh;
    logic [2:0]         gl;
    logic [DW-1:0]      dcnt [3];

    assign at_zero = (cnt == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    // Count 0 uses the live inputs so the period's first vector is on time.
    assign s_sec = at_zero ? sector : lat_sector;
    assign s_t0  = at_zero ? t0 : lat_t0;
    assign s_t1  = at_zero ? t1 : lat_t1;
    assign s_t2  = at_zero ? t2 : lat_t2;
    assign s_t7  = at_zero ? t7 : lat_t7;

    assign sum_in = BW'(t0) + BW'(t1) + BW'(t2) + BW'(t7);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lat_sector   <= '0;
            lat_t0       <= '0;
            lat_t1       <= '0;
            lat_t2       <= '0;
            lat_t7       <= '0;
            run          <= 1'b0;
            period_start <= 1'b0;
            sum_error    <= 1'b0;
            sector_error <= 1'b0;
        end else begin
            period_start <= at_zero;
            if (at_zero) begin
                lat_sector   <= sector;
                lat_t0       <= t0;
                lat_t1       <= t1;
                lat_t2       <= t2;
                lat_t7       <= t7;
                run          <= enable;
                sum_error    <= (sum_in != BW'(PERIOD));
                sector_error <= (sector > 3'd5);
            end else if (!enable) begin
                run <= 1'b0;
            end
        end
    end

    assign drive = enable && (at_zero || run);

    always_comb begin
        h0 = BW'(s_t0 >> 1);
        h1 = BW'(s_t1 >> 1);
        h2 = BW'(s_t2 >> 1);
        b1 = h0;
        b2 = b1 + h1;
        b3 = b2 + h2;
        b4 = b3 + BW'(s_t7);
        b5 = b4 + (BW'(s_t2) - h2);
        b6 = b5 + (BW'(s_t1) - h1);
    end

    assign c = BW'(cnt);

    // Va/Vb ordering keeps every transition to a single leg.
    always_comb begin
        va     = V0;
        vb     = V0;
        sec_ok = 1'b1;
        unique case (s_sec)
            3'd0: begin va = V1; vb = V2; end
            3'd1: begin va = V3; vb = V2; end
            3'd2: begin va = V3; vb = V4; end
            3'd3: begin va = V5; vb = V4; end
            3'd4: begin va = V5; vb = V6; end
            3'd5: begin va = V1; vb = V6; end
            default: sec_ok = 1'b0;
        endcase
    end

    always_comb begin
        cmd = V0;
        unique case (1'b1)
            (c < b1):               cmd = V0;
            (c >= b1) && (c < b2):  cmd = va;
            (c >= b2) && (c < b3):  cmd = vb;
            (c >= b3) && (c < b4):  cmd = V7;
            (c >= b4) && (c < b5):  cmd = vb;
            (c >= b5) && (c < b6):  cmd = va;
            (c >= b6):              cmd = V0;
        endcase
        if (!sec_ok) begin
            cmd = V0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tgt <= '0;
            gh  <= '0;
            gl  <= '0;
            for (int i = 0; i < 3; i++) begin
                dcnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (!drive) begin
                    tgt[i]  <= 1'b0;
                    gh[i]   <= 1'b0;
                    gl[i]   <= 1'b0;
                    dcnt[i] <= '0;
                end else if (cmd[i] != tgt[i]) begin
                    tgt[i] <= cmd[i];
                    if (DEAD_TIME == 0) begin
                        gh[i]   <= cmd[i];
                        gl[i]   <= !cmd[i];
                        dcnt[i] <= '0;
                    end else begin
                        gh[i]   <= 1'b0;
                        gl[i]   <= 1'b0;
                        dcnt[i] <= DW'(DEAD_TIME);
                    end
                end else if (dcnt[i] > DW'(1)) begin
                    dcnt[i] <= dcnt[i] - DW'(1);
                    gh[i]   <= 1'b0;
                    gl[i]   <= 1'b0;
                end else begin
                    dcnt[i] <= '0;
                    gh[i]   <= tgt[i];
                    gl[i]   <= !tgt[i];
                end
            end
        end
    end

    assign u_h = gh[2];
    assign u_l = gl[2];
    assign v_h = gh[1];
    assign v_l = gl[1];
    assign w_h = gh[0];
    assign w_l = gl[0];

endmodule

// File: tb/tb_ac_motor_vector_pwm.sv
// Bench for ac_motor_vector_pwm: two instances (no dead time, short dead
// time) compared every clock against a segment-walk reference model.
module tb_ac_motor_vector_pwm;

    localparam int P    = 400;
    localparam int CLKF = P * 5000;
    localparam int DT   = 5;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic [2:0]  sector = '0;
    logic [14:0] t0 = '0;
    logic [14:0] t1 = '0;
    logic [14:0] t2 = '0;
    logic [14:0] t7 = '0;

    logic [5:0]  ga;
    logic [5:0]  gb;
    logic        ps_a, se_a, ce_a;
    logic        ps_b, se_b, ce_b;

    int vectors = 0;
    int miscompares = 0;
    int rel = -1;

    always #5 clk = ~clk;

    ac_motor_vector_pwm #(
        .CLK_FREQ(CLKF), .PWM_FREQ(5000), .T_WIDTH(15), .DEAD_TIME(0)
    ) dut_a (
        .clk(clk), .reset(reset), .enable(enable), .sector(sector),
        .t0(t0), .t1(t1), .t2(t2), .t7(t7),
        .u_h(ga[5]), .u_l(ga[4]), .v_h(ga[3]), .v_l(ga[2]),
        .w_h(ga[1]), .w_l(ga[0]),
        .period_start(ps_a), .sum_error(se_a), .sector_error(ce_a)
    );

    ac_motor_vector_pwm #(
        .CLK_FREQ(CLKF), .PWM_FREQ(5000), .T_WIDTH(15), .DEAD_TIME(DT)
    ) dut_b (
        .clk(clk), .reset(reset), .enable(enable), .sector(sector),
        .t0(t0), .t1(t1), .t2(t2), .t7(t7),
        .u_h(gb[5]), .u_l(gb[4]), .v_h(gb[3]), .v_l(gb[2]),
        .w_h(gb[1]), .w_l(gb[0]),
        .period_start(ps_b), .sum_error(se_b), .sector_error(ce_b)
    );

    // Walk the seven segments; vectors numbered by angle, Va is the odd one.
    function automatic logic [2:0] exp_vec(input int s, input int a0,
                                           input int a1, input int a2,
                                           input int a7, input int k);
        logic [2:0] legs [8];
        int dur [6];
        int seq [6];
        int va, vb, pos;
        legs = '{3'b000, 3'b100, 3'b110, 3'b010,
                 3'b011, 3'b001, 3'b101, 3'b111};
        if (s > 5) return 3'b000;
        va = s + 1;
        vb = (s + 1) % 6 + 1;
        if (va % 2 == 0) begin
            pos = va; va = vb; vb = pos;
        end
        dur = '{a0 / 2, a1 / 2, a2 / 2, a7, a2 - a2 / 2, a1 - a1 / 2};
        seq = '{0, va, vb, 7, vb, va};
        pos = k;
        for (int i = 0; i < 6; i++) begin
            if (pos < dur[i]) return legs[seq[i]];
            pos -= dur[i];
        end
        return 3'b000;
    endfunction

    initial begin : model
        int mn, lat, last_drop, msec, k, dt;
        int mt [4];
        int mchg [2][3];
        logic mtgt [2][3];
        logic msum, mcerr, drv, cb;
        logic [2:0] cmd;
        logic [8:0] ex [2];
        logic [8:0] got [2];
        mn = -1; lat = 0; last_drop = -1; msec = 0;
        mt = '{0, 0, 0, 0};
        msum = 1'b0; mcerr = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                mn = -1; lat = 0; last_drop = -1; msec = 0;
                mt = '{0, 0, 0, 0};
                msum = 1'b0; mcerr = 1'b0;
                for (int d = 0; d < 2; d++) begin
                    for (int i = 0; i < 3; i++) begin
                        mtgt[d][i] = 1'b0;
                        mchg[d][i] = -1000000;
                    end
                    ex[d] = '0;
                end
            end else begin
                mn++;
                k = mn % P;
                if (k == 0) begin
                    lat = mn;
                    msec = int'(sector);
                    mt[0] = int'(t0); mt[1] = int'(t1);
                    mt[2] = int'(t2); mt[3] = int'(t7);
                    msum = (mt[0] + mt[1] + mt[2] + mt[3]) != P;
                    mcerr = sector > 3'd5;
                end
                if (!enable) last_drop = mn;
                drv = last_drop < lat;
                cmd = exp_vec(msec, mt[0], mt[1], mt[2], mt[3], k);
                for (int d = 0; d < 2; d++) begin
                    dt = (d == 0) ? 0 : DT;
                    ex[d] = '0;
                    ex[d][2] = (k == 0);
                    ex[d][1] = msum;
                    ex[d][0] = mcerr;
                    for (int i = 0; i < 3; i++) begin
                        cb = cmd[2 - i];
                        if (!drv) begin
                            mtgt[d][i] = 1'b0;
                            mchg[d][i] = -1000000;
                        end else begin
                            if (cb != mtgt[d][i]) begin
                                mtgt[d][i] = cb;
                                mchg[d][i] = mn;
                            end
                            if (mn - mchg[d][i] >= dt) begin
                                ex[d][8 - 2 * i] = mtgt[d][i];
                                ex[d][7 - 2 * i] = !mtgt[d][i];
                            end
                        end
                    end
                end
            end
            got[0] = {ga, ps_a, se_a, ce_a};
            got[1] = {gb, ps_b, se_b, ce_b};
            for (int d = 0; d < 2; d++) begin
                vectors++;
                if (got[d] !== ex[d]) begin
                    miscompares++;
                    $display("FAIL cycle dut%0d n=%0d: got %b want %b",
                             d, mn, got[d], ex[d]);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [5:0] act,
                       input logic [5:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b want %b", nm, act, exp);
        end
    endtask

    task automatic run_to(input int r);
        while (rel < r) begin
            @(posedge clk);
            rel++;
        end
        #1;
    endtask

    task automatic set_std(input int s);
        sector = 3'(s);
        t0 = 15'd200; t1 = 15'd80; t2 = 15'd80; t7 = 15'd40;
    endtask

    task automatic set_rand();
        int a, b, c, d, e;
        a = int'($urandom_range(0, 150));
        b = int'($urandom_range(0, 150));
        c = int'($urandom_range(0, P - a - b - 4));
        d = P - a - b - c;
        if ($urandom_range(0, 3) == 0) begin
            e = int'($urandom_range(0, 20));
            c = c + e - 10;
            if (c < 0) c = 0;
        end
        t0 = 15'(d); t1 = 15'(a); t2 = 15'(b); t7 = 15'(c);
        sector = 3'($urandom_range(0, 7));
        enable = ($urandom_range(0, 5) != 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset_a", {ga[5:0]}, 6'b000000);
        chk("reset_b", {gb[5:0]}, 6'b000000);
        chk("reset_flags", {3'b000, ps_a, se_a, ce_a}, 6'b000000);
        @(negedge clk);
        set_std(0);
        enable = 1'b1;
        reset = 1'b0;
        rel = -1;

        run_to(0);
        chk("ps_first", {5'b0, ps_a}, 6'd1);
        chk("sum_ok", {5'b0, se_a}, 6'd0);
        run_to(99);   chk("uh@99", {5'b0, ga[5]}, 6'd0);
        run_to(100);  chk("uh@100", {5'b0, ga[5]}, 6'd1);
        chk("ul@100", {5'b0, ga[4]}, 6'd0);
        chk("dt_u@100", {4'b0, gb[5:4]}, 6'd0);
        run_to(104);  chk("dt_uh@104", {5'b0, gb[5]}, 6'd0);
        run_to(105);  chk("dt_uh@105", {5'b0, gb[5]}, 6'd1);
        run_to(139);  chk("vh@139", {5'b0, ga[3]}, 6'd0);
        run_to(140);  chk("vh@140", {5'b0, ga[3]}, 6'd1);
        run_to(219);  chk("wh@219", {5'b0, ga[1]}, 6'd1);
        run_to(220);  chk("wh@220", {5'b0, ga[1]}, 6'd0);
        run_to(299);  chk("uh@299", {5'b0, ga[5]}, 6'd1);
        run_to(300);  chk("u@300", {4'b0, ga[5:4]}, 6'b000001);
        run_to(304);  chk("dt_ul@304", {5'b0, gb[4]}, 6'd0);
        run_to(305);  chk("dt_ul@305", {5'b0, gb[4]}, 6'd1);
        @(negedge clk); set_std(1);
        run_to(500);  chk("s1_vh", {5'b0, ga[3]}, 6'd1);
        run_to(539);  chk("s1_uh@139", {5'b0, ga[5]}, 6'd0);
        run_to(540);  chk("s1_uh@140", {5'b0, ga[5]}, 6'd1);
        @(negedge clk); set_std(0); t0 = 15'd195;
        run_to(800);  chk("sum_short", {5'b0, se_a}, 6'd1);
        run_to(1198); chk("pad_v0", ga, 6'b010101);
        @(negedge clk); set_std(0); t0 = 15'd210;
        run_to(1200); chk("sum_long", {5'b0, se_a}, 6'd1);
        @(negedge clk); set_std(7);
        run_to(1600); chk("sec_err", {5'b0, ce_a}, 6'd1);
        run_to(1800); chk("sec_v0", ga, 6'b010101);
        @(negedge clk); set_std(0);
        run_to(2000); chk("sec_clear", {5'b0, ce_a}, 6'd0);
        run_to(2560); @(negedge clk); enable = 1'b0;
        run_to(2561); chk("dis_a", ga, 6'b000000);
        chk("dis_b", gb, 6'b000000);
        run_to(2640); @(negedge clk); enable = 1'b1;
        run_to(2799); chk("en_wait", ga, 6'b000000);
        run_to(2800); chk("en_ps", {5'b0, ps_a}, 6'd1);
        chk("en_v0", ga, 6'b010101);
        run_to(2950);
        #2 reset = 1'b1;
        #1 chk("async_a", ga, 6'b000000);
        chk("async_b", gb, 6'b000000);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        rel = -1;
        run_to(0);    chk("ps_after_rst", {5'b0, ps_a}, 6'd1);

        for (int j = 1; j <= 20; j++) begin
            run_to((j - 1) * P + int'($urandom_range(5, P - 10)));
            @(negedge clk);
            sector = 3'($urandom);
            t0 = 15'($urandom); t1 = 15'($urandom);
            t2 = 15'($urandom); t7 = 15'($urandom);
            if ($urandom_range(0, 3) == 0) enable = 1'b0;
            run_to(j * P - 1);
            @(negedge clk);
            set_rand();
        end
        run_to(21 * P);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
